// File: rtl/amf_scan_ctrl.sv
// amf_scan_ctrl: raster-scan sequencer for the adaptive median filter.
// Requests window stats, runs stage A/B, writes each output pixel.
module amf_scan_ctrl #(
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64,
  parameter int DW      = 8,
  parameter int XW      = 6,
  parameter int YW      = 6,
  parameter int AW      = 12,
  parameter int MAX_LVL = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          endF,
  output logic          win_req,
  input  logic          win_rdy,
  output logic [XW-1:0] win_x,
  output logic [YW-1:0] win_y,
  output logic [1:0]    win_lvl,
  input  logic          st_valid,
  input  logic [DW-1:0] zmin,
  input  logic [DW-1:0] zmed,
  input  logic [DW-1:0] zmax,
  input  logic [DW-1:0] zxy,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic [AW:0]   repl_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_EVAL,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [AW:0] ONE = 1;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [1:0]    lvl_q, lvl_d;
  logic [DW-1:0] min_q, min_d;
  logic [DW-1:0] med_q, med_d;
  logic [DW-1:0] max_q, max_d;
  logic [DW-1:0] cxy_q, cxy_d;
  logic [DW-1:0] out_q, out_d;
  logic [AW:0]   repl_q, repl_d;

  logic stage_a;
  logic keep_c;
  logic last_x;
  logic last_y;

  assign stage_a = (min_q < med_q) && (med_q < max_q);
  assign keep_c  = (min_q < cxy_q) && (cxy_q < max_q);
  assign last_x  = (x_q == XW'(IMG_W - 1));
  assign last_y  = (y_q == YW'(IMG_H - 1));

  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign endF     = (state_q == S_DONE);
  assign win_req  = (state_q == S_REQ);
  assign wr_en    = (state_q == S_WRITE);
  assign win_x    = x_q;
  assign win_y    = y_q;
  assign win_lvl  = lvl_q;
  assign wr_addr  = AW'(y_q) * AW'(IMG_W) + AW'(x_q);
  assign wr_data  = out_q;
  assign repl_cnt = repl_q;

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      lvl_q   <= '0;
      min_q   <= '0;
      med_q   <= '0;
      max_q   <= '0;
      cxy_q   <= '0;
      out_q   <= '0;
      repl_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      lvl_q   <= lvl_d;
      min_q   <= min_d;
      med_q   <= med_d;
      max_q   <= max_d;
      cxy_q   <= cxy_d;
      out_q   <= out_d;
      repl_q  <= repl_d;
    end
  end

  // Next-state: scan order, level escalation and the A/B decision.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    lvl_d   = lvl_q;
    min_d   = min_q;
    med_d   = med_q;
    max_d   = max_q;
    cxy_d   = cxy_q;
    out_d   = out_q;
    repl_d  = repl_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_REQ;
          x_d     = '0;
          y_d     = '0;
          lvl_d   = '0;
          repl_d  = '0;
        end
      end
      S_REQ: begin
        if (win_rdy) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (st_valid) begin
          min_d   = zmin;
          med_d   = zmed;
          max_d   = zmax;
          cxy_d   = zxy;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (stage_a) begin
          out_d   = keep_c ? cxy_q : med_q;
          state_d = S_WRITE;
        end else if (lvl_q < 2'(MAX_LVL)) begin
          lvl_d   = lvl_q + 2'd1;
          state_d = S_REQ;
        end else begin
          out_d   = med_q;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (out_q != cxy_q) repl_d = repl_q + ONE;
        lvl_d = '0;
        if (last_x && last_y) begin
          state_d = S_DONE;
        end else if (last_x) begin
          x_d     = '0;
          y_d     = y_q + 1'b1;
          state_d = S_REQ;
        end else begin
          x_d     = x_q + 1'b1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_amf_scan_ctrl.sv
// tb_amf_scan_ctrl: directed + random frames on a 4x2 image,
// stats unit and expected output computed inside the bench.
module tb_amf_scan_ctrl;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int N  = W * H;
  localparam int DW = 8;
  localparam int XW = 2;
  localparam int YW = 1;
  localparam int AW = 3;
  localparam int ML = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          busy, endF, win_req, wr_en;
  logic          win_rdy = 1'b0;
  logic          st_valid = 1'b0;
  logic [XW-1:0] win_x;
  logic [YW-1:0] win_y;
  logic [1:0]    win_lvl;
  logic [DW-1:0] zmin = '0, zmed = '0, zmax = '0, zxy = '0;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW:0]   repl_cnt;

  amf_scan_ctrl #(
    .IMG_W(W), .IMG_H(H), .DW(DW), .XW(XW),
    .YW(YW), .AW(AW), .MAX_LVL(ML)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .endF(endF),
    .win_req(win_req), .win_rdy(win_rdy),
    .win_x(win_x), .win_y(win_y), .win_lvl(win_lvl),
    .st_valid(st_valid),
    .zmin(zmin), .zmed(zmed), .zmax(zmax), .zxy(zxy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .repl_cnt(repl_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] tbl [N][3][4];
  int exp_req[$];
  int exp_wa[$];
  int exp_wd[$];
  int exp_repl;
  int exp_lat;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rv();
    if ($urandom_range(0, 1) == 0) return 8'($urandom_range(0, 6));
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic fill(input int mode);
    for (int p = 0; p < N; p++)
      for (int l = 0; l < 3; l++) begin
        case (mode)
          0: tbl[p][l] = '{8'd10, 8'd50, 8'd90, 8'd60};
          1: tbl[p][l] = '{8'd10, 8'd50, 8'd90, 8'd255};
          2: if (l < 2) tbl[p][l] = '{8'd20, 8'd20, 8'd90, 8'd0};
             else tbl[p][l] = '{8'd10, 8'd30, 8'd90, 8'd0};
          3: tbl[p][l] = '{8'd40, 8'd40, 8'd40, 8'd0};
          default: begin
            for (int k = 0; k < 4; k++) tbl[p][l][k] = rv();
          end
        endcase
      end
  endtask

  // Adaptive median rule applied per pixel, level by level.
  task automatic build_model();
    int o, l, zi, zm, za, zc;
    exp_req.delete();
    exp_wa.delete();
    exp_wd.delete();
    exp_repl = 0;
    exp_lat = 0;
    for (int p = 0; p < N; p++) begin
      o = 0;
      zc = 0;
      for (l = 0; l <= ML; l++) begin
        zi = tbl[p][l][0];
        zm = tbl[p][l][1];
        za = tbl[p][l][2];
        zc = tbl[p][l][3];
        exp_req.push_back(p * 4 + l);
        exp_lat += 3;
        if (zi < zm && zm < za) begin
          o = (zi < zc && zc < za) ? zc : zm;
          break;
        end
        o = zm;
      end
      exp_lat += 1;
      exp_wa.push_back(p);
      exp_wd.push_back(o);
      if (o != zc) exp_repl++;
    end
  endtask

  task automatic run_frame(input bit slow, input bit abort);
    int cyc, reqcyc, dly, pp, pl, e;
    bit acc_pend, prev_req, got_end;
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic [1:0] plv;
    logic [AW:0] rc;
    cyc = 0; reqcyc = 0; dly = 0; pp = 0; pl = 0;
    acc_pend = 0; prev_req = 0; got_end = 0;
    px = '0; py = '0; plv = '0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < 3000) begin
      chk("busy_vs_endF", busy, !endF);
      if (endF) begin
        got_end = 1;
        break;
      end
      if (wr_en) begin
        if (exp_wa.size() == 0) chk("extra_write", 1, 0);
        else begin
          chk("wr_addr", wr_addr, exp_wa.pop_front());
          chk("wr_data", wr_data, exp_wd.pop_front());
        end
      end
      if (prev_req && win_req)
        chk("req_stable", {win_x, win_y, win_lvl}, {px, py, plv});
      prev_req = win_req;
      px = win_x; py = win_y; plv = win_lvl;
      st_valid = 1'b0;
      zmin = rv(); zmed = rv(); zmax = rv(); zxy = rv();
      if (acc_pend) begin
        if (abort && pp == 3) begin
          win_rdy = 1'b0;
          rst = 1'b0;
          @(negedge clk);
          chk("rst_outs",
              {busy, endF, win_req, wr_en, win_x, win_y,
               win_lvl, wr_addr, wr_data, repl_cnt}, 0);
          @(negedge clk);
          chk("rst_no_write", wr_en, 0);
          rst = 1'b1;
          @(negedge clk);
          chk("rst_idle", {busy, wr_en}, 0);
          return;
        end
        if (dly == 0) begin
          st_valid = 1'b1;
          zmin = tbl[pp][pl][0];
          zmed = tbl[pp][pl][1];
          zmax = tbl[pp][pl][2];
          zxy  = tbl[pp][pl][3];
          acc_pend = 0;
        end else dly--;
      end
      win_rdy = 1'b0;
      if (win_req) begin
        reqcyc++;
        if (slow && reqcyc == 2) st_valid = 1'b1;
        win_rdy = slow ? (reqcyc > 5) : 1'b1;
        if (win_rdy) begin
          pp = int'(win_y) * W + int'(win_x);
          pl = (win_lvl > 2) ? 2 : int'(win_lvl);
          e = (exp_req.size() > 0) ? exp_req.pop_front() : -1;
          chk("req_xyl", pp * 4 + int'(win_lvl), e);
          acc_pend = 1;
          dly = slow ? 3 : 0;
          reqcyc = 0;
        end
      end
      start = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    win_rdy = 1'b0;
    st_valid = 1'b0;
    chk("frame_done", got_end, 1);
    if (!slow) chk("latency", cyc, exp_lat);
    chk("writes_left", exp_wa.size(), 0);
    chk("reqs_left", exp_req.size(), 0);
    chk("repl_cnt", repl_cnt, exp_repl);
    rc = repl_cnt;
    repeat (3) @(negedge clk);
    chk("done_hold", {endF, busy, wr_en, repl_cnt}, {3'b100, rc});
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outs",
        {busy, endF, win_req, wr_en, win_x, win_y,
         win_lvl, wr_addr, wr_data, repl_cnt}, 0);
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    fill(0); build_model(); run_frame(0, 0);
    chk("lat32", exp_lat, 32);
    fill(1); build_model(); run_frame(0, 0);
    fill(2); build_model(); run_frame(0, 0);
    fill(3); build_model(); run_frame(0, 0);
    fill(0); build_model(); run_frame(1, 0);
    for (int i = 0; i < 6; i++) begin
      fill(4); build_model(); run_frame(i[0], 0);
    end
    fill(0); build_model(); run_frame(0, 1);
    fill(1); build_model(); run_frame(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/amf_scan_ctrl.md
Name: amf_scan_ctrl

Overview:
Sequencing controller for the adaptive median filter datapath. Raster-scans an IMG_W x IMG_H image, requests window statistics (min/median/max/centre) from the window-stats unit at growing window sizes, applies the adaptive median stage A/B decision, writes each output pixel, and raises endF when the frame is complete. Sits between the top-level start/endF control and the window-stats unit and output image memory.

Parameters:
IMG_W, 64, image width in pixels
IMG_H, 64, image height in pixels
DW, 8, pixel data width
XW, 6, column coordinate width (clog2 IMG_W)
YW, 6, row coordinate width (clog2 IMG_H)
AW, 12, output address width (clog2 IMG_W*IMG_H)
MAX_LVL, 2, largest window level (0=3x3, 1=5x5, 2=7x7)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-low
start  in  1  begin frame; sampled only in IDLE/DONE
busy  out  1  high from frame start until last write
endF  out  1  frame complete; held high in DONE
win_req  out  1  window-stats request valid
win_rdy  in  1  stats unit accepts request
win_x  out  XW  centre column of requested window
win_y  out  YW  centre row of requested window
win_lvl  out  2  window level of request
st_valid  in  1  stats result valid (one-cycle pulse)
zmin, zmed, zmax, zxy  in  DW each  window min, median, max, centre pixel
wr_en  out  1  output pixel write strobe (always accepted)
wr_addr  out  AW  y*IMG_W + x
wr_data  out  DW  filtered pixel
repl_cnt  out  AW+1  pixels this frame with wr_data != zxy

Behaviour:
- rst=0 at a clock edge: state IDLE; busy, endF, win_req, wr_en = 0; win_x/win_y/win_lvl, wr_addr, wr_data, repl_cnt = 0; latched stats cleared. Reset mid-frame abandons frame, no further writes.
- States: IDLE, REQ, WAIT, EVAL, WRITE, DONE.
- IDLE: start=1 -> REQ; x=y=0, lvl=0, repl_cnt=0, busy=1.
- REQ: win_req=1 with current x/y/lvl held stable; win_req&win_rdy -> WAIT (win_req drops next cycle).
- WAIT: st_valid=1 -> latch zmin/zmed/zmax/zxy, -> EVAL. st_valid outside WAIT ignored.
- EVAL (1 cycle, unsigned compares on latched values):
  - stage A passes if zmin < zmed < zmax: out = (zmin < zxy < zmax) ? zxy : zmed -> WRITE.
  - else if lvl < MAX_LVL: lvl+1 -> REQ (same x,y).
  - else out = zmed -> WRITE.
- WRITE: wr_en=1 for exactly one cycle with wr_addr, wr_data=out; repl_cnt+1 if out != zxy; lvl reset to 0. If x=IMG_W-1 and y=IMG_H-1 -> DONE; else x+1 (wrap to 0 with y+1 at x=IMG_W-1) -> REQ.
- DONE: endF=1, busy=0, outputs hold; repl_cnt holds final value. start=1 -> same as IDLE start, endF=0 next cycle.
- start while busy ignored. Border handling (edge replication) is the stats unit's job; controller always issues in-range x,y.
- Minimum per-level latency: REQ 1 + WAIT 1 + EVAL 1 cycles; per pixel +1 for WRITE. Frame of N pixels all resolved at level 0 with zero-wait stats: 4N cycles start-to-endF.
- Simultaneous rst=0 and start=1: reset wins.

Test Plan:
- IMG_W=4, IMG_H=2, stats model win_rdy=1, st_valid 1 cycle after accept, zmin=10 zmed=50 zmax=90 zxy=60 -> 8 writes, addr 0..7, data 60, repl_cnt=0, endF high exactly 32 cycles after start.
- Same, zxy=255 (impulse) -> every wr_data=50, repl_cnt=8.
- zmin=zmed=20 zmax=90 at lvl 0 and 1, zmin=10 zmed=30 zmax=90 zxy=0 at lvl 2 -> requests lvl 0,1,2 for each pixel, wr_data=30.
- zmin=zmed=zmax=40 at all levels, zxy=0 -> three requests per pixel then wr_data=40 at MAX_LVL.
- win_rdy held low 5 cycles, st_valid delayed 3 cycles, spurious st_valid in REQ -> win_x/y/lvl stable while win_req, spurious pulse ignored, results unchanged.
- rst=0 during WAIT of pixel 3 -> all outputs 0 next cycle, no wr_en; new start rescans from addr 0 with repl_cnt=0.
